// File: rtl/if_fetch_unit.sv
// ---------------------------------------------------------------------------
// if_fetch_unit
//   Instruction-fetch stage of a 5-stage RV32I pipeline. It owns the PC and
//   the IF/ID pipeline register. It fetches from instruction memory over a
//   req/ack handshake. It honours the ID-stage stall (IFWrite) and applies
//   Branch/Jump redirects. Every redirect flushes IF/ID to a NOP.
//
// Ports
//   clk             in   1   rising-edge clock
//   reset           in   1   synchronous, active-high reset
//   IFWrite         in   1   1 = IF/ID may advance, 0 = load-use stall
//   Branch          in   1   taken branch from EX (outranks Jump)
//   BranchAddr      in   32  branch target
//   Jump            in   1   jal/jalr from ID
//   JumpAddr        in   32  jump target
//   imem_req        out  1   fetch request
//   imem_addr       out  32  fetch address (current PC)
//   imem_ack        in   1   imem_rdata valid this cycle
//   imem_rdata      in   32  fetched instruction
//   Instruction_id  out  32  IF/ID instruction
//   PC_id           out  32  IF/ID PC
// ---------------------------------------------------------------------------
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        IFWrite,
    input  logic        Branch,
    input  logic [31:0] BranchAddr,
    input  logic        Jump,
    input  logic [31:0] JumpAddr,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] Instruction_id,
    output logic [31:0] PC_id
);

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,   // request outstanding at pc_r
        ST_HOLD  = 2'd1,   // word fetched but ID stalled; kept in buf_r
        ST_DRAIN = 2'd2    // redirect arrived mid-request; wait out the stale ack
    } state_t;

    state_t      state_r;
    logic [31:0] pc_r;
    logic [31:0] tgt_r;
    logic [31:0] buf_r;
    logic [31:0] instr_id_r;
    logic [31:0] pc_id_r;
    logic        req_r;

    logic        redirect_s;
    logic [31:0] target_s;
    logic [31:0] pc_inc_s;

    // Redirect decode: Branch comes from EX (older instruction), so it wins over Jump.
    always_comb begin
        redirect_s = Branch | Jump;
        if (Branch) begin
            target_s = BranchAddr;
        end else begin
            target_s = JumpAddr;
        end
        pc_inc_s = pc_r + 32'd4;   // wraps silently past 32'hFFFF_FFFC
    end

    // Fetch FSM, PC, redirect target, stall buffer and IF/ID register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= ST_FETCH;
            pc_r       <= RESET_PC;
            tgt_r      <= RESET_PC;
            buf_r      <= NOP_INSTR;
            instr_id_r <= NOP_INSTR;
            pc_id_r    <= 32'h0000_0000;
            req_r      <= 1'b1;
        end else begin
            case (state_r)
                ST_FETCH: begin
                    if (imem_ack) begin
                        if (redirect_s) begin
                            // Fetched word is on the wrong path: drop it.
                            pc_r       <= target_s;
                            instr_id_r <= NOP_INSTR;
                            pc_id_r    <= 32'h0000_0000;
                        end else if (IFWrite) begin
                            instr_id_r <= imem_rdata;
                            pc_id_r    <= pc_r;
                            pc_r       <= pc_inc_s;
                        end else begin
                            // ID is stalled: park the word, stop requesting.
                            buf_r   <= imem_rdata;
                            state_r <= ST_HOLD;
                            req_r   <= 1'b0;
                        end
                    end else begin
                        if (redirect_s) begin
                            // Address must stay stable until the ack, so remember
                            // the target and let the stale request complete.
                            tgt_r      <= target_s;
                            state_r    <= ST_DRAIN;
                            instr_id_r <= NOP_INSTR;
                            pc_id_r    <= 32'h0000_0000;
                        end else if (IFWrite) begin
                            instr_id_r <= NOP_INSTR;
                            pc_id_r    <= 32'h0000_0000;
                        end else begin
                            state_r <= ST_FETCH;
                        end
                    end
                end
                ST_HOLD: begin
                    if (redirect_s) begin
                        pc_r       <= target_s;
                        state_r    <= ST_FETCH;
                        req_r      <= 1'b1;
                        instr_id_r <= NOP_INSTR;
                        pc_id_r    <= 32'h0000_0000;
                    end else if (IFWrite) begin
                        instr_id_r <= buf_r;
                        pc_id_r    <= pc_r;
                        pc_r       <= pc_inc_s;
                        state_r    <= ST_FETCH;
                        req_r      <= 1'b1;
                    end else begin
                        state_r <= ST_HOLD;
                    end
                end
                ST_DRAIN: begin
                    if (redirect_s || IFWrite) begin
                        instr_id_r <= NOP_INSTR;
                        pc_id_r    <= 32'h0000_0000;
                    end else begin
                        instr_id_r <= instr_id_r;
                    end
                    if (imem_ack) begin
                        // Stale data is discarded; the newest redirect wins.
                        if (redirect_s) begin
                            pc_r <= target_s;
                        end else begin
                            pc_r <= tgt_r;
                        end
                        state_r <= ST_FETCH;
                    end else if (redirect_s) begin
                        tgt_r <= target_s;
                    end else begin
                        state_r <= ST_DRAIN;
                    end
                end
                default: begin
                    // Illegal encoding: recover to a clean fetch with a bubble in ID.
                    state_r    <= ST_FETCH;
                    req_r      <= 1'b1;
                    instr_id_r <= NOP_INSTR;
                    pc_id_r    <= 32'h0000_0000;
                end
            endcase
        end
    end

    // Request is low for the whole time reset is asserted, including the first reset cycle.
    assign imem_req       = req_r & ~reset;
    assign imem_addr      = pc_r;
    assign Instruction_id = instr_id_r;
    assign PC_id          = pc_id_r;

endmodule
